vga_scan_timing: RTL and testbench
==================================

Name: vga_scan_timing

Overview:
- Generates 640x480@60 Hz VGA scan timing: the horCnt/verCnt pixel coordinates that all sprite and background renderers consume, plus hsync/vsync to the connector.
- Closes the loop on the renderer side. It takes the merged 6-bit RGB that the renderers compute from the current coordinates, registers it, and blanks it outside the active area.
- Sits at the top level between the 100 MHz board clock, the renderer mux and the VGA pins.

Parameters:
- CLK_DIV, 4: board clocks per pixel; legal range 1..16.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VIS, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  input  1  board clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- rgb_in  input  6  pixel colour from renderers for the current (horCnt, verCnt).
- horCnt  output  10  current horizontal pixel count, 0..H_TOTAL-1.
- verCnt  output  10  current line count, 0..V_TOTAL-1.
- pix_tick  output  1  one-clk pixel enable.
- video_on  output  1  high when horCnt<H_VIS and verCnt<V_VIS.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- rgb_out  output  6  registered, blanked pixel to DAC pins.
- frame_start  output  1  one-clk pulse at the start of each frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state is updated on the rising edge of clk.
- Totals:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 480+10+2+33 = 525.
  - All count arithmetic is 10-bit unsigned; the parameters must keep the totals ≤1024.
- Reset values:
  - divider=0, horCnt=0, verCnt=0.
  - hsync=1, vsync=1, rgb_out=0, frame_start=0.
  - pix_tick is 0 while in reset, or constant 1 when CLK_DIV=1.
- Reset mid-frame: all of the above are forced immediately (asynchronously). The scan restarts from (0,0) with a full divider period.
- Prescaler:
  - The divider counts 0..CLK_DIV-1 and then wraps.
  - pix_tick = (divider==CLK_DIV-1), decoded from the register.
  - First pix_tick occurs in the CLK_DIV-th cycle after rst_n rises.
- On each clk edge where pix_tick=1, all of the following happen in the same edge, based on the pre-edge counts (h, v):
  - rgb_out <= (h<H_VIS && v<V_VIS) ? rgb_in : 0.
  - hsync <= ~(h >= H_VIS+H_FP && h < H_VIS+H_FP+H_SYNC), i.e. low for h 656..751.
  - vsync <= ~(v >= V_VIS+V_FP && v < V_VIS+V_FP+V_SYNC), i.e. low for v 490..491.
  - horCnt advances: h==H_TOTAL-1 → 0, else h+1.
  - verCnt advances only when h==H_TOTAL-1: v==V_TOTAL-1 → 0, else v+1.
  - frame_start <= (h==H_TOTAL-1 && v==V_TOTAL-1).
- Pipeline alignment:
  - rgb_out, hsync and vsync lag horCnt/verCnt by exactly one pixel period, so the pins stay mutually aligned.
  - rgb_in is sampled only on pix_tick edges. Renderers have the full CLK_DIV-1 cycles to settle.
- On edges where pix_tick=0: frame_start <= 0, and all other registers hold.
- frame_start is therefore high for exactly one clk, coinciding with the first cycle in which the counts read (0,0).
- video_on is combinational from horCnt/verCnt and has no register.
- Counts never leave their legal ranges, including across reset release.
- CLK_DIV=1: every edge is a pixel edge.

Test Plan:
- Reset: hold rst_n=0 for 10 clk, then release.
  - During reset: horCnt=0, verCnt=0, hsync=1, vsync=1, rgb_out=0, frame_start=0.
  - First pix_tick at the 4th clk after release; horCnt=1 after that edge.
- Line timing, CLK_DIV=4:
  - hsync falls on the pix_tick edge where the pre-edge horCnt=656.
  - It stays low for 96 ticks (384 clk).
  - Period is 800 ticks (3200 clk).
  - verCnt increments once per line.
- Frame timing:
  - vsync is low for exactly 2 lines (1600 ticks), starting when verCnt=490.
  - frame_start pulses exactly once every 420,000 ticks (1,680,000 clk), each pulse one clk wide.
- Blanking: hold rgb_in=6'b111111 constant.
  - rgb_out=6'b111111 for the ticks sampling h 0..639 on lines 0..479.
  - rgb_out=0 for h 640..799, and for all of lines 480..524.
  - video_on matches the same windows one tick earlier.
- Sampling: drive rgb_in=horCnt[5:0].
  - After each pix_tick edge with pre-edge h<640, rgb_out equals that pre-edge h[5:0].
  - Toggling rgb_in between ticks does not change rgb_out.
- Mid-frame reset: assert rst_n=0 at horCnt=300, verCnt=200 for 3 clk, then release.
  - Outputs return to reset values immediately on the rst_n fall, without waiting for a clk edge.
  - After release, the scan restarts at (0,0).
  - The next frame_start occurs 1,680,000 clk after release.

Source files
------------

// File: rtl/vga_scan_timing.sv
// VGA scan timing: pixel prescaler, horizontal/vertical counters, syncs and
// the registered, blanked pixel that leaves for the DAC pins.
module vga_scan_timing #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rgb_in,
    output logic [9:0] horCnt,
    output logic [9:0] verCnt,
    output logic       pix_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb_out,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Window bounds carry an 11th bit so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_B = 11'(H_VIS);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_B = 11'(V_VIS);
    localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] divider;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;
    logic             h_last;
    logic             v_last;
    logic             h_in_sync;
    logic             v_in_sync;

    function automatic logic [5:0] blank_pix(input logic vis, input logic [5:0] pix);
        return vis ? pix : 6'd0;
    endfunction

    assign h_ext     = {1'b0, horCnt};
    assign v_ext     = {1'b0, verCnt};
    assign h_last    = (horCnt == H_LAST);
    assign v_last    = (verCnt == V_LAST);
    assign h_in_sync = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign v_in_sync = (v_ext >= VS_BEG) && (v_ext < VS_END);
    assign video_on  = (h_ext < H_VIS_B) && (v_ext < V_VIS_B);
    assign pix_tick  = (divider == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= '0;
        end else if (pix_tick) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // Pixel stage: pins are computed from the pre-edge counts, so they trail the counts by one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            horCnt      <= '0;
            verCnt      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb_out     <= '0;
            frame_start <= 1'b0;
        end else if (pix_tick) begin
            rgb_out     <= blank_pix(video_on, rgb_in);
            hsync       <= !h_in_sync;
            vsync       <= !v_in_sync;
            horCnt      <= h_last ? 10'd0 : horCnt + 10'd1;
            if (h_last) begin
                verCnt <= v_last ? 10'd0 : verCnt + 10'd1;
            end
            frame_start <= h_last && v_last;
        end else begin
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: full-size 640x480 instance at CLK_DIV=4 for line timing, plus a
// shrunken CLK_DIV=1 instance (16x10 totals) so whole frames fit in a short run.
module tb_vga_scan_timing;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_s_n;
    logic [5:0] rgb_in, rgb_s_in;
    logic [9:0] horCnt, verCnt, horCnt_s, verCnt_s;
    logic       pix_tick, video_on, hsync, vsync, frame_start;
    logic       pix_tick_s, video_on_s, hsync_s, vsync_s, frame_start_s;
    logic [5:0] rgb_out, rgb_out_s;

    int total = 0;
    int bad   = 0;

    vga_scan_timing dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
        .horCnt(horCnt), .verCnt(verCnt), .pix_tick(pix_tick), .video_on(video_on),
        .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out), .frame_start(frame_start)
    );

    // Small geometry: hsync low for h 10..12, vsync low for v 7..8, visible 8x6.
    vga_scan_timing #(
        .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_s_n), .rgb_in(rgb_s_in),
        .horCnt(horCnt_s), .verCnt(verCnt_s), .pix_tick(pix_tick_s), .video_on(video_on_s),
        .hsync(hsync_s), .vsync(vsync_s), .rgb_out(rgb_out_s), .frame_start(frame_start_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_main(input int h, input int v);
        int n = 0;
        while (!(horCnt == 10'(h) && verCnt == 10'(v) && pix_tick === 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_main", 32'(n < 20000), 1);
    endtask

    task automatic wait_small(input int h, input int v);
        int n = 0;
        while (!(horCnt_s == 10'(h) && verCnt_s == 10'(v)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_small", 32'(n < 2000), 1);
    endtask

    initial begin
        int n;
        logic [5:0] exp6;

        rst_n = 1'b0; rst_s_n = 1'b0;
        rgb_in = 6'h3F; rgb_s_in = 6'h3F;
        repeat (10) @(negedge clk);

        chk("rst_hor", horCnt, 0);
        chk("rst_ver", verCnt, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_rgb", rgb_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_tick", pix_tick, 0);
        chk("rst_tick_div1", pix_tick_s, 1);

        rst_n = 1'b1; rst_s_n = 1'b1;
        @(negedge clk);
        chk("div1_hor_after_1", horCnt_s, 1);
        @(negedge clk);
        chk("tick_not_yet", pix_tick, 0);
        chk("hor_hold", horCnt, 0);
        @(negedge clk);
        chk("first_tick", pix_tick, 1);
        @(negedge clk);
        chk("hor_after_tick", horCnt, 1);
        chk("tick_cleared", pix_tick, 0);

        // Line timing on the full-size instance
        wait_main(656, 0);
        chk("hsync_pre_fall", hsync, 1);
        @(negedge clk);
        chk("hsync_fall", hsync, 0);
        n = 0;
        while (hsync === 1'b0 && n < 5000) begin @(negedge clk); n++; end
        chk("hsync_low_clk", n, 384);
        while (hsync === 1'b1 && n < 10000) begin @(negedge clk); n++; end
        chk("hsync_period_clk", n, 3200);
        chk("hsync_fall2_hor", horCnt, 657);
        chk("ver_per_line", verCnt, 1);

        // Horizontal blanking with constant white input
        wait_main(639, 2);
        chk("von_last_vis", video_on, 1);
        @(negedge clk);
        chk("rgb_last_vis", rgb_out, 6'h3F);
        chk("von_first_blank", video_on, 0);
        repeat (4) @(negedge clk);
        chk("rgb_first_blank", rgb_out, 0);
        wait_main(799, 2);
        chk("von_h799", video_on, 0);
        @(negedge clk);
        chk("rgb_h799", rgb_out, 0);
        chk("wrap_hor", horCnt, 0);
        chk("wrap_ver", verCnt, 3);
        chk("von_line_start", video_on, 1);
        repeat (4) @(negedge clk);
        chk("rgb_h0", rgb_out, 6'h3F);

        // Sampling: rgb_in follows h[5:0] at each tick and is scrambled between ticks
        wait_main(100, 3);
        for (int k = 0; k < 4; k++) begin
            exp6 = 6'((100 + k) % 64);
            chk("samp_hor", horCnt, 32'(100 + k));
            rgb_in = exp6;
            @(negedge clk);
            chk("samp_rgb", rgb_out, exp6);
            for (int j = 0; j < 3; j++) begin
                rgb_in = ~exp6 ^ 6'(j);
                @(negedge clk);
                chk("samp_hold", rgb_out, exp6);
            end
        end

        // Mid-line asynchronous reset
        rgb_in = 6'h2A;
        wait_main(300, 3);
        @(negedge clk);
        chk("pre_rst_rgb", rgb_out, 6'h2A);
        #2 rst_n = 1'b0;
        #1;
        chk("async_hor", horCnt, 0);
        chk("async_ver", verCnt, 0);
        chk("async_rgb", rgb_out, 0);
        chk("async_tick", pix_tick, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rerun_tick", pix_tick, 1);
        chk("rerun_hor0", horCnt, 0);
        @(negedge clk);
        chk("rerun_hor1", horCnt, 1);
        chk("rerun_ver", verCnt, 0);

        // Frame timing on the small instance
        wait_small(15, 6);
        chk("vsync_pre", vsync_s, 1);
        @(negedge clk);
        chk("ver_7", verCnt_s, 7);
        chk("vsync_lag", vsync_s, 1);
        @(negedge clk);
        chk("vsync_fall", vsync_s, 0);
        n = 0;
        while (vsync_s === 1'b0 && n < 1000) begin @(negedge clk); n++; end
        chk("vsync_low_clk", n, 32);

        n = 0;
        while (frame_start_s !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("fs_hor", horCnt_s, 0);
        chk("fs_ver", verCnt_s, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("fs_width", frame_start_s, 0);
        end while (frame_start_s !== 1'b1 && n < 1000);
        chk("fs_period", n, 160);

        // Vertical blanking
        wait_small(5, 5);
        chk("von_s_vis", video_on_s, 1);
        @(negedge clk);
        chk("rgb_s_vis", rgb_out_s, 6'h3F);
        wait_small(5, 6);
        chk("von_s_vblank", video_on_s, 0);
        @(negedge clk);
        chk("rgb_s_vblank", rgb_out_s, 0);

        // Mid-frame reset on the small instance; next frame_start one full frame later
        wait_small(5, 3);
        @(negedge clk);
        chk("s_pre_rst_rgb", rgb_out_s, 6'h3F);
        #2 rst_s_n = 1'b0;
        #1;
        chk("s_async_hor", horCnt_s, 0);
        chk("s_async_ver", verCnt_s, 0);
        chk("s_async_rgb", rgb_out_s, 0);
        repeat (3) @(negedge clk);
        rst_s_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("s_rerun_hor", horCnt_s, 1);
        end while (frame_start_s !== 1'b1 && n < 1000);
        chk("s_fs_after_rst", n, 160);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
